i3c_bus_access_arbiter: RTL



---
 rtl/i3c_bus_access_arbiter_if.sv | 46 ++++
 rtl/i3c_bus_access_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/i3c_bus_access_arbiter_if.sv
// Bus-access handshake bundle between the arbiter, the i3c timer FSM
// and the SDR/HDR/CRH engines that request the bus.
interface i3c_bus_access_arbiter_if;
   logic [3:0] i_req;
   logic [3:0] i_done;
   logic       i_timer_cas;
   logic       i_timer_bus_free_pure;
   logic       i_timer_bus_aval;
   logic       i_timer_bus_idle;
   logic       i_timer_crhpol;
   logic       o_start_pattern;
   logic       o_stop_pattern;
   logic [3:0] o_grant;
   logic       o_busy;
   logic       o_timeout;

   modport master (
      input  i_req,
      input  i_done,
      input  i_timer_cas,
      input  i_timer_bus_free_pure,
      input  i_timer_bus_aval,
      input  i_timer_bus_idle,
      input  i_timer_crhpol,
      output o_start_pattern,
      output o_stop_pattern,
      output o_grant,
      output o_busy,
      output o_timeout
   );

   modport slave (
      output i_req,
      output i_done,
      output i_timer_cas,
      output i_timer_bus_free_pure,
      output i_timer_bus_aval,
      output i_timer_bus_idle,
      output i_timer_crhpol,
      input  o_start_pattern,
      input  o_stop_pattern,
      input  o_grant,
      input  o_busy,
      input  o_timeout
   );
endinterface

// File: rtl/i3c_bus_access_arbiter.sv
// I3C controller bus-access arbiter: gates four requesters on timer bus flags.
// Define I3C_ARB_RR_EN for round-robin selection instead of fixed 3>2>1>0.
module i3c_bus_access_arbiter #(
   parameter int HOLD_MAX = 4096,
   parameter int CNT_W    = 16
) (
   input logic                       i_clk,
   input logic                       i_rst,
   i3c_bus_access_arbiter_if.master  bus
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_READY,
      S_START,
      S_GRANT,
      S_STOP
   } state_t;

   state_t           state;
   logic [1:0]       owner;
   logic [CNT_W-1:0] cnt;
   logic             stop_armed;
   logic             start_q;
   logic             stop_q;
   logic [3:0]       grant_q;
   logic             busy_q;
   logic             to_q;

   logic [3:0]       elig;
   logic [1:0]       win;
   logic             any_elig;
   logic             owner_req;
   logic             owner_done;
   logic             hold_end;

   always_comb begin
      elig = bus.i_req & {bus.i_timer_crhpol,
                          bus.i_timer_bus_idle,
                          bus.i_timer_bus_aval,
                          bus.i_timer_bus_free_pure};
      any_elig = |elig;
   end

`ifdef I3C_ARB_RR_EN
   logic [1:0] ptr;
   logic [1:0] idx;
   logic       found;

   // Search starts one past the last winner so every eligible index gets a turn.
   always_comb begin
      win   = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && elig[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win = 2'd0;
      priority case (1'b1)
         elig[3]: win = 2'd3;
         elig[2]: win = 2'd2;
         elig[1]: win = 2'd1;
         default: win = 2'd0;
      endcase
   end
`endif

   always_comb begin
      owner_req  = bus.i_req[owner];
      owner_done = bus.i_done[owner];
      hold_end   = (cnt == CNT_W'(HOLD_MAX - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_BOOT;
         owner      <= 2'd0;
         cnt        <= '0;
         stop_armed <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         grant_q    <= 4'd0;
         busy_q     <= 1'b0;
         to_q       <= 1'b0;
`ifdef I3C_ARB_RR_EN
         ptr        <= 2'd0;
`endif
      end else begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         to_q    <= 1'b0;
         unique case (state)
            S_BOOT: begin
               busy_q <= !bus.i_timer_bus_idle;
               if (bus.i_timer_bus_idle)
                  state <= S_READY;
            end
            S_READY: begin
               busy_q <= any_elig;
               if (any_elig) begin
                  owner   <= win;
                  start_q <= 1'b1;
                  state   <= S_START;
`ifdef I3C_ARB_RR_EN
                  ptr     <= win;
`endif
               end
            end
            S_START: begin
               busy_q <= 1'b1;
               if (bus.i_timer_cas) begin
                  grant_q <= 4'b0001 << owner;
                  cnt     <= '0;
                  state   <= S_GRANT;
               end
            end
            S_GRANT: begin
               busy_q <= 1'b1;
               if (owner_done || !owner_req || hold_end) begin
                  grant_q    <= 4'd0;
                  stop_q     <= 1'b1;
                  to_q       <= hold_end && !owner_done;
                  stop_armed <= 1'b0;
                  cnt        <= '0;
                  state      <= S_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               cnt <= '0;
               // The first STOP cycle may still see bus-free from before the stop.
               if (!stop_armed) begin
                  stop_armed <= 1'b1;
                  busy_q     <= 1'b1;
               end else begin
                  busy_q <= !bus.i_timer_bus_free_pure;
                  if (bus.i_timer_bus_free_pure)
                     state <= S_READY;
               end
            end
            default: begin
               busy_q <= 1'b1;
               state  <= S_BOOT;
            end
         endcase
      end
   end

   assign bus.o_start_pattern = start_q;
   assign bus.o_stop_pattern  = stop_q;
   assign bus.o_grant         = grant_q;
   assign bus.o_busy          = busy_q;
   assign bus.o_timeout       = to_q;

   a_start_stop_excl: assert property (
      @(posedge i_clk) disable iff (i_rst) !(start_q && stop_q));

   a_grant_onehot: assert property (
      @(posedge i_clk) disable iff (i_rst) $onehot0(grant_q));

endmodule
